// File: rtl/uart_frame_parser.sv
// uart_frame_parser
//   Parses a byte stream of packets into a command FIFO and a data FIFO.
//   Packet: header {instr, lenf}, optional length-extension byte, L payload
//   bytes, optional XOR checksum byte.
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   rx_data/valid/rdy byte input handshake (accept = rx_valid && rx_ready)
//   cmd_wr/instr/len/err, cmd_free   command FIFO write port + free count
//   data_wr/byte, data_free          data FIFO write port + free count
//   pkt_error, err_code              error pulse + code of the last error
//                                    (1 checksum, 2 timeout, 3 data FIFO full)
//   busy                             high while a packet is in progress
module uart_frame_parser #(
    parameter int INSTR_W     = 4,
    parameter int LEN_W       = 4,
    parameter int EXT_LEN     = 1,
    parameter int CHK_EN      = 1,
    parameter int TIMEOUT_CYC = 1000,
    parameter int FREE_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic               cmd_wr,
    output logic [INSTR_W-1:0] cmd_instr,
    output logic [7:0]         cmd_len,
    output logic               cmd_err,
    input  logic [FREE_W-1:0]  cmd_free,
    output logic               data_wr,
    output logic [7:0]         data_byte,
    input  logic [FREE_W-1:0]  data_free,
    output logic               pkt_error,
    output logic [1:0]         err_code,
    output logic               busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_EXT   = 3'd1;
    localparam logic [2:0] S_SPACE = 3'd2;
    localparam logic [2:0] S_PAY   = 3'd3;
    localparam logic [2:0] S_CHK   = 3'd4;

    localparam int TMO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int TMO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
    localparam int CMP_W    = (FREE_W > 8) ? FREE_W : 8;

    logic [2:0]         state;
    logic [INSTR_W-1:0] instr_r;
    logic [7:0]         len_r;
    logic [7:0]         cnt;
    logic [7:0]         chk_acc;
    logic [TMO_W-1:0]   tmo;
    logic               ovf_seen;

    logic               accept;
    logic [INSTR_W-1:0] hdr_instr;
    logic [LEN_W-1:0]   hdr_lenf;
    logic               hdr_ext;
    logic [7:0]         dec_len;
    logic               space_ok;
    logic [2:0]         dec_next;
    logic               dec_issue;
    logic               timeout;
    logic [7:0]         cnt_inc;

    always_comb begin
        rx_ready = 1'b1;
        if (state == S_SPACE) begin
            rx_ready = 1'b0;
        end else if (state == S_PAY && data_free == '0) begin
            rx_ready = 1'b0;
        end
        busy      = (state != S_IDLE);
        accept    = rx_valid && rx_ready;
        hdr_instr = rx_data[7:8-INSTR_W];
        hdr_lenf  = rx_data[LEN_W-1:0];
        hdr_ext   = (EXT_LEN != 0) && (&hdr_lenf);
        cnt_inc   = cnt + 8'd1;
        timeout   = (TIMEOUT_CYC != 0) && (tmo == TMO_W'(TMO_LAST));

        // Length the post-header decision is based on, depending on where it is made.
        case (state)
            S_IDLE:  dec_len = 8'(hdr_lenf);
            S_EXT:   dec_len = rx_data;
            default: dec_len = len_r;
        endcase
        space_ok = (cmd_free != '0) && (CMP_W'(data_free) >= CMP_W'(dec_len));

        // Shared decision for IDLE, EXT and SPACE exits; dec_issue means the
        // packet is complete right now (zero length, no checksum).
        dec_issue = 1'b0;
        if (!space_ok) begin
            dec_next = S_SPACE;
        end else if (dec_len != 8'd0) begin
            dec_next = S_PAY;
        end else if (CHK_EN != 0) begin
            dec_next = S_CHK;
        end else begin
            dec_next  = S_IDLE;
            dec_issue = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            instr_r   <= '0;
            len_r     <= '0;
            cnt       <= '0;
            chk_acc   <= '0;
            tmo       <= '0;
            ovf_seen  <= 1'b0;
            cmd_wr    <= 1'b0;
            cmd_instr <= '0;
            cmd_len   <= '0;
            cmd_err   <= 1'b0;
            data_wr   <= 1'b0;
            data_byte <= '0;
            pkt_error <= 1'b0;
            err_code  <= '0;
        end else begin
            cmd_wr    <= 1'b0;
            data_wr   <= 1'b0;
            pkt_error <= 1'b0;
            case (state)
                S_IDLE: begin
                    tmo <= '0;
                    if (accept) begin
                        instr_r  <= hdr_instr;
                        chk_acc  <= rx_data;
                        cnt      <= '0;
                        ovf_seen <= 1'b0;
                        len_r    <= dec_len;
                        if (hdr_ext) begin
                            state <= S_EXT;
                        end else begin
                            state <= dec_next;
                            if (dec_issue) begin
                                cmd_wr    <= 1'b1;
                                cmd_instr <= hdr_instr;
                                cmd_len   <= dec_len;
                                cmd_err   <= 1'b0;
                            end
                        end
                    end
                end
                S_EXT: begin
                    if (accept) begin
                        len_r   <= rx_data;
                        chk_acc <= chk_acc ^ rx_data;
                        tmo     <= '0;
                        state   <= dec_next;
                        if (dec_issue) begin
                            cmd_wr    <= 1'b1;
                            cmd_instr <= instr_r;
                            cmd_len   <= dec_len;
                            cmd_err   <= 1'b0;
                        end
                    end else if (timeout) begin
                        state     <= S_IDLE;
                        pkt_error <= 1'b1;
                        err_code  <= 2'd2;
                    end else if (TIMEOUT_CYC != 0) begin
                        tmo <= tmo + 1'b1;
                    end
                end
                S_SPACE: begin
                    tmo <= '0;
                    if (space_ok) begin
                        state <= dec_next;
                        if (dec_issue) begin
                            cmd_wr    <= 1'b1;
                            cmd_instr <= instr_r;
                            cmd_len   <= len_r;
                            cmd_err   <= 1'b0;
                        end
                    end
                end
                S_PAY: begin
                    if (accept) begin
                        data_wr   <= 1'b1;
                        data_byte <= rx_data;
                        chk_acc   <= chk_acc ^ rx_data;
                        cnt       <= cnt_inc;
                        tmo       <= '0;
                        if (cnt_inc == len_r) begin
                            if (CHK_EN != 0) begin
                                state <= S_CHK;
                            end else begin
                                state     <= S_IDLE;
                                cmd_wr    <= 1'b1;
                                cmd_instr <= instr_r;
                                cmd_len   <= len_r;
                                cmd_err   <= 1'b0;
                            end
                        end
                    end else if (timeout) begin
                        state     <= S_IDLE;
                        pkt_error <= 1'b1;
                        err_code  <= 2'd2;
                        cmd_wr    <= 1'b1;
                        cmd_instr <= instr_r;
                        cmd_len   <= cnt;
                        cmd_err   <= 1'b1;
                    end else begin
                        if (TIMEOUT_CYC != 0) begin
                            tmo <= tmo + 1'b1;
                        end
                        // Full data FIFO is reported once per packet, not per stalled cycle.
                        if (data_free == '0 && !ovf_seen) begin
                            ovf_seen  <= 1'b1;
                            pkt_error <= 1'b1;
                            err_code  <= 2'd3;
                        end
                    end
                end
                S_CHK: begin
                    if (accept) begin
                        state     <= S_IDLE;
                        tmo       <= '0;
                        cmd_wr    <= 1'b1;
                        cmd_instr <= instr_r;
                        cmd_len   <= len_r;
                        cmd_err   <= (chk_acc != rx_data);
                        if (chk_acc != rx_data) begin
                            pkt_error <= 1'b1;
                            err_code  <= 2'd1;
                        end
                    end else if (timeout) begin
                        state     <= S_IDLE;
                        pkt_error <= 1'b1;
                        err_code  <= 2'd2;
                        cmd_wr    <= 1'b1;
                        cmd_instr <= instr_r;
                        cmd_len   <= cnt;
                        cmd_err   <= 1'b1;
                    end else if (TIMEOUT_CYC != 0) begin
                        tmo <= tmo + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
